// File: rtl/nx_msg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nx_msg_pkg
// Description : Shared definitions for the node message stream. Holds the
//               command and direction encodings, field widths, packed layouts
//               of the message header and payloads, and the routing helper.
//               Used by nx_msg_decoder here and by nx_node_control for
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nx_msg_pkg;

  // Field widths of a message: [31:28] row, [27:24] col, [23:22] cmd,
  // [21:0] payload.
  localparam int MSG_STREAM_W  = 32;
  localparam int MSG_ROW_W     = 4;
  localparam int MSG_COL_W     = 4;
  localparam int MSG_CMD_W     = 2;
  localparam int MSG_PAYLOAD_W = 22;
  localparam int MSG_IDX_W     = 3;

  typedef enum logic [MSG_CMD_W-1:0] {
    CMD_LOAD_INSTR = 2'd0,
    CMD_MAP_OUTPUT = 2'd1,
    CMD_SIG_STATE  = 2'd2,
    CMD_RESERVED   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    DIRX_NORTH = 2'd0,
    DIRX_EAST  = 2'd1,
    DIRX_SOUTH = 2'd2,
    DIRX_WEST  = 2'd3
  } dir_e;

  typedef struct packed {
    logic [MSG_ROW_W-1:0]     row;
    logic [MSG_COL_W-1:0]     col;
    cmd_e                     cmd;
    logic [MSG_PAYLOAD_W-1:0] payload;
  } msg_hdr_t;

  // MAP_OUTPUT payload: [14:12] idx, [11:8] tgt_row, [7:4] tgt_col,
  // [3:1] tgt_idx, [0] seq.
  typedef struct packed {
    logic [6:0]           rsvd;
    logic [MSG_IDX_W-1:0] idx;
    logic [MSG_ROW_W-1:0] tgt_row;
    logic [MSG_COL_W-1:0] tgt_col;
    logic [MSG_IDX_W-1:0] tgt_idx;
    logic                 seq;
  } map_payload_t;

  // SIG_STATE payload: [4:2] index, [1] is_seq, [0] state.
  typedef struct packed {
    logic [16:0]          rsvd;
    logic [MSG_IDX_W-1:0] index;
    logic                 is_seq;
    logic                 state;
  } sig_payload_t;

  // Row-first routing: resolve the row difference before the column.
  function automatic dir_e route_dir(
    input logic [MSG_ROW_W-1:0] row,
    input logic [MSG_COL_W-1:0] col,
    input logic [MSG_ROW_W-1:0] node_row,
    input logic [MSG_COL_W-1:0] node_col
  );
    dir_e dir;
    if (row > node_row)      dir = DIRX_SOUTH;
    else if (row < node_row) dir = DIRX_NORTH;
    else if (col > node_col) dir = DIRX_EAST;
    else                     dir = DIRX_WEST;
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nx_fifo
// Description : Small synchronous FIFO with full/empty flags. Head entry is
//               presented combinationally on data_o. A push while full and a
//               pop while empty are ignored.
// Ports       : clk_i, rst_i (async active-low), push_i/data_i (write side),
//               pop_i/data_o (read side), full_o, empty_o.
// Revision    : 1.0 - initial release
// ============================================================================
module nx_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nx_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nx_msg_decoder
// Description : Inbound end of the node message stream. Messages addressed
//               to this node are decoded into registered one-cycle strobes
//               (map, signal, instruction, error). Messages for other nodes
//               are tagged with a route direction and queued in a bypass
//               FIFO.
// Ports       : clk_i, rst_i (async active-low), node_row_i/node_col_i
//               (own address), msg_* (inbound valid/ready), byp_* (forward
//               valid/ready with direction), map_*, signal_*, instr_*
//               (local strobes and fields), error_o, idle_o.
// Revision    : 1.0 - initial release
// ============================================================================
module nx_msg_decoder
  import nx_msg_pkg::*;
#(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 2,
  parameter int INPUTS         = 8,
  parameter int OUTPUTS        = 8,
  parameter int INSTR_WIDTH    = 22,
  parameter int BYPASS_DEPTH   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0]  node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]  node_col_i,
  input  logic [STREAM_WIDTH-1:0]    msg_data_i,
  input  logic                       msg_valid_i,
  output logic                       msg_ready_o,
  output logic [STREAM_WIDTH-1:0]    byp_data_o,
  output logic [1:0]                 byp_dir_o,
  output logic                       byp_valid_o,
  input  logic                       byp_ready_i,
  output logic [$clog2(OUTPUTS)-1:0] map_idx_o,
  output logic [ADDR_ROW_WIDTH-1:0]  map_tgt_row_o,
  output logic [ADDR_COL_WIDTH-1:0]  map_tgt_col_o,
  output logic [$clog2(INPUTS)-1:0]  map_tgt_idx_o,
  output logic                       map_tgt_seq_o,
  output logic                       map_valid_o,
  output logic [$clog2(INPUTS)-1:0]  signal_index_o,
  output logic                       signal_is_seq_o,
  output logic                       signal_state_o,
  output logic                       signal_valid_o,
  output logic [INSTR_WIDTH-1:0]     instr_data_o,
  output logic                       instr_valid_o,
  output logic                       error_o,
  output logic                       idle_o
);

  localparam int HDR_W  = ADDR_ROW_WIDTH + ADDR_COL_WIDTH + COMMAND_WIDTH;
  localparam int PL_W   = STREAM_WIDTH - HDR_W;
  localparam int FIFO_W = STREAM_WIDTH + 2;
  localparam int OIDX_W = $clog2(OUTPUTS);
  localparam int IIDX_W = $clog2(INPUTS);

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [ADDR_ROW_WIDTH-1:0] msg_row;
  logic [ADDR_COL_WIDTH-1:0] msg_col;
  cmd_e                      msg_cmd;
  logic [PL_W-1:0]           msg_payload;
  map_payload_t              map_pl;
  sig_payload_t              sig_pl;
  logic                      unused_rsvd;

  assign msg_row     = msg_data_i[STREAM_WIDTH-1 -: ADDR_ROW_WIDTH];
  assign msg_col     = msg_data_i[STREAM_WIDTH-ADDR_ROW_WIDTH-1 -: ADDR_COL_WIDTH];
  assign msg_cmd     = cmd_e'(msg_data_i[PL_W +: COMMAND_WIDTH]);
  assign msg_payload = msg_data_i[PL_W-1:0];
  assign map_pl      = map_payload_t'(msg_payload);
  assign sig_pl      = sig_payload_t'(msg_payload);
  assign unused_rsvd = ^{map_pl.rsvd, sig_pl.rsvd};

  // --------------------------------------------------------------------------
  // Accept / route
  // --------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic is_local;
  logic fifo_push;
  logic fifo_pop;
  dir_e msg_dir;
  logic [FIFO_W-1:0] fifo_head;

  // Ready is a pure function of occupancy: a pop in the same cycle does not
  // reopen the input, which keeps byp_ready_i off the msg_ready_o path.
  assign msg_ready_o = !fifo_full;
  assign accept      = msg_valid_i && msg_ready_o;
  assign is_local    = (msg_row == node_row_i) && (msg_col == node_col_i);
  assign msg_dir     = route_dir(msg_row, msg_col, node_row_i, node_col_i);
  assign fifo_push   = accept && !is_local;
  assign fifo_pop    = byp_valid_o && byp_ready_i;

  nx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (BYPASS_DEPTH)
  ) u_bypass_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  ({msg_dir, msg_data_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign byp_valid_o = !fifo_empty;
  assign byp_dir_o   = fifo_head[FIFO_W-1 -: 2];
  assign byp_data_o  = fifo_head[STREAM_WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Local decode: strobes default low, data fields hold unless reloaded
  // --------------------------------------------------------------------------
  logic                      map_valid_q,     map_valid_d;
  logic [OIDX_W-1:0]         map_idx_q,       map_idx_d;
  logic [ADDR_ROW_WIDTH-1:0] map_tgt_row_q,   map_tgt_row_d;
  logic [ADDR_COL_WIDTH-1:0] map_tgt_col_q,   map_tgt_col_d;
  logic [IIDX_W-1:0]         map_tgt_idx_q,   map_tgt_idx_d;
  logic                      map_tgt_seq_q,   map_tgt_seq_d;
  logic                      signal_valid_q,  signal_valid_d;
  logic [IIDX_W-1:0]         signal_index_q,  signal_index_d;
  logic                      signal_is_seq_q, signal_is_seq_d;
  logic                      signal_state_q,  signal_state_d;
  logic                      instr_valid_q,   instr_valid_d;
  logic [INSTR_WIDTH-1:0]    instr_data_q,    instr_data_d;
  logic                      error_q,         error_d;

  always_comb begin
    map_valid_d     = 1'b0;
    signal_valid_d  = 1'b0;
    instr_valid_d   = 1'b0;
    error_d         = 1'b0;
    map_idx_d       = map_idx_q;
    map_tgt_row_d   = map_tgt_row_q;
    map_tgt_col_d   = map_tgt_col_q;
    map_tgt_idx_d   = map_tgt_idx_q;
    map_tgt_seq_d   = map_tgt_seq_q;
    signal_index_d  = signal_index_q;
    signal_is_seq_d = signal_is_seq_q;
    signal_state_d  = signal_state_q;
    instr_data_d    = instr_data_q;
    if (accept && is_local) begin
      case (msg_cmd)
        CMD_MAP_OUTPUT: begin
          map_valid_d   = 1'b1;
          map_idx_d     = map_pl.idx;
          map_tgt_row_d = map_pl.tgt_row;
          map_tgt_col_d = map_pl.tgt_col;
          map_tgt_idx_d = map_pl.tgt_idx;
          map_tgt_seq_d = map_pl.seq;
        end
        CMD_SIG_STATE: begin
          signal_valid_d  = 1'b1;
          signal_index_d  = sig_pl.index;
          signal_is_seq_d = sig_pl.is_seq;
          signal_state_d  = sig_pl.state;
        end
        CMD_LOAD_INSTR: begin
          instr_valid_d = 1'b1;
          instr_data_d  = msg_payload[INSTR_WIDTH-1:0];
        end
        default: begin
          error_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      map_valid_q     <= 1'b0;
      map_idx_q       <= '0;
      map_tgt_row_q   <= '0;
      map_tgt_col_q   <= '0;
      map_tgt_idx_q   <= '0;
      map_tgt_seq_q   <= 1'b0;
      signal_valid_q  <= 1'b0;
      signal_index_q  <= '0;
      signal_is_seq_q <= 1'b0;
      signal_state_q  <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_data_q    <= '0;
      error_q         <= 1'b0;
    end else begin
      map_valid_q     <= map_valid_d;
      map_idx_q       <= map_idx_d;
      map_tgt_row_q   <= map_tgt_row_d;
      map_tgt_col_q   <= map_tgt_col_d;
      map_tgt_idx_q   <= map_tgt_idx_d;
      map_tgt_seq_q   <= map_tgt_seq_d;
      signal_valid_q  <= signal_valid_d;
      signal_index_q  <= signal_index_d;
      signal_is_seq_q <= signal_is_seq_d;
      signal_state_q  <= signal_state_d;
      instr_valid_q   <= instr_valid_d;
      instr_data_q    <= instr_data_d;
      error_q         <= error_d;
    end
  end

  assign map_valid_o     = map_valid_q;
  assign map_idx_o       = map_idx_q;
  assign map_tgt_row_o   = map_tgt_row_q;
  assign map_tgt_col_o   = map_tgt_col_q;
  assign map_tgt_idx_o   = map_tgt_idx_q;
  assign map_tgt_seq_o   = map_tgt_seq_q;
  assign signal_valid_o  = signal_valid_q;
  assign signal_index_o  = signal_index_q;
  assign signal_is_seq_o = signal_is_seq_q;
  assign signal_state_o  = signal_state_q;
  assign instr_valid_o   = instr_valid_q;
  assign instr_data_o    = instr_data_q;
  assign error_o         = error_q;

  assign idle_o = fifo_empty && !msg_valid_i &&
                  !(map_valid_q || signal_valid_q || instr_valid_q || error_q);

endmodule
`default_nettype wire

// File: tb/tb_nx_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nx_msg_decoder
// Description : Scoreboard bench for nx_msg_decoder. Stimulus pushes expected
//               local strobes and forwarded messages into queues; a monitor
//               on the falling edge pops and compares whatever the DUT shows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nx_msg_decoder;

  localparam logic [3:0] NODE_ROW = 4'd2;
  localparam logic [3:0] NODE_COL = 4'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  node_row = NODE_ROW;
  logic [3:0]  node_col = NODE_COL;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] byp_data;
  logic [1:0]  byp_dir;
  logic        byp_valid;
  logic        byp_ready;
  logic [2:0]  map_idx;
  logic [3:0]  map_tgt_row;
  logic [3:0]  map_tgt_col;
  logic [2:0]  map_tgt_idx;
  logic        map_tgt_seq;
  logic        map_valid;
  logic [2:0]  signal_index;
  logic        signal_is_seq;
  logic        signal_state;
  logic        signal_valid;
  logic [21:0] instr_data;
  logic        instr_valid;
  logic        error;
  logic        idle;

  always #5 clk = ~clk;

  nx_msg_decoder dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .node_row_i      (node_row),
    .node_col_i      (node_col),
    .msg_data_i      (msg_data),
    .msg_valid_i     (msg_valid),
    .msg_ready_o     (msg_ready),
    .byp_data_o      (byp_data),
    .byp_dir_o       (byp_dir),
    .byp_valid_o     (byp_valid),
    .byp_ready_i     (byp_ready),
    .map_idx_o       (map_idx),
    .map_tgt_row_o   (map_tgt_row),
    .map_tgt_col_o   (map_tgt_col),
    .map_tgt_idx_o   (map_tgt_idx),
    .map_tgt_seq_o   (map_tgt_seq),
    .map_valid_o     (map_valid),
    .signal_index_o  (signal_index),
    .signal_is_seq_o (signal_is_seq),
    .signal_state_o  (signal_state),
    .signal_valid_o  (signal_valid),
    .instr_data_o    (instr_data),
    .instr_valid_o   (instr_valid),
    .error_o         (error),
    .idle_o          (idle)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct { logic [1:0] cmd; logic [21:0] pl; } loc_t;
  typedef struct { logic [31:0] data; logic [1:0] dir; } byp_t;

  loc_t exp_loc[$];
  byp_t exp_byp[$];
  int   total = 0;
  int   bad   = 0;

  logic [41:0] hold;
  logic        prev_stall;
  logic [33:0] prev_head;
  logic        rand_ready = 1'b0;
  loc_t        mon_loc;
  byp_t        mon_byp;

  wire [3:0]  act_stb    = {error, instr_valid, signal_valid, map_valid};
  wire [41:0] act_fields = {map_idx, map_tgt_row, map_tgt_col, map_tgt_idx, map_tgt_seq,
                            signal_index, signal_is_seq, signal_state, instr_data};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_local(input logic [31:0] m);
    int unsigned r = 32'(m >> 28) & 15;
    int unsigned c = 32'(m >> 24) & 15;
    return (r == 32'(NODE_ROW)) && (c == 32'(NODE_COL));
  endfunction

  function automatic logic [1:0] ref_dir(input logic [31:0] m);
    int unsigned r = 32'(m >> 28) & 15;
    int unsigned c = 32'(m >> 24) & 15;
    if (r > 32'(NODE_ROW)) return 2'd2;
    if (r < 32'(NODE_ROW)) return 2'd0;
    if (c > 32'(NODE_COL)) return 2'd1;
    return 2'd3;
  endfunction

  function automatic logic [3:0] ref_stb(input logic [1:0] cmd);
    case (cmd)
      2'd0:    return 4'b0100;
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [41:0] ref_hold(input loc_t e, input logic [41:0] h);
    int unsigned p = 32'(e.pl);
    logic [41:0] n = h;
    case (e.cmd)
      2'd1: n[41:27] = {3'(p >> 12), 4'(p >> 8), 4'(p >> 4), 3'(p >> 1), 1'(p)};
      2'd2: n[26:22] = {3'(p >> 2), 1'(p >> 1), 1'(p)};
      2'd0: n[21:0]  = 22'(p);
      default: n = h;
    endcase
    return n;
  endfunction

  function automatic void expect_msg(input logic [31:0] m);
    loc_t l;
    byp_t b;
    if (ref_local(m)) begin
      l.cmd = 2'(m >> 22);
      l.pl  = 22'(m);
      exp_loc.push_back(l);
    end else begin
      b.data = m;
      b.dir  = ref_dir(m);
      exp_byp.push_back(b);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_loc.delete();
      exp_byp.delete();
      hold       = '0;
      prev_stall = 1'b0;
    end else begin
      if (act_stb != 4'b0) begin
        if (exp_loc.size() == 0) begin
          check("unexpected_strobe", 64'(act_stb), 64'd0);
        end else begin
          mon_loc = exp_loc.pop_front();
          check("strobe_kind", 64'(act_stb), 64'(ref_stb(mon_loc.cmd)));
          hold = ref_hold(mon_loc, hold);
          check("strobe_fields", 64'(act_fields), 64'(hold));
        end
      end else begin
        check("hold_fields", 64'(act_fields), 64'(hold));
      end
      if (prev_stall) begin
        check("stall_stable", {29'd0, byp_valid, byp_dir, byp_data}, {29'd0, 1'b1, prev_head});
      end
      if (byp_valid && byp_ready) begin
        if (exp_byp.size() == 0) begin
          check("unexpected_forward", 64'(byp_data), 64'd0);
        end else begin
          mon_byp = exp_byp.pop_front();
          check("fwd_data", 64'(byp_data), 64'(mon_byp.data));
          check("fwd_dir", 64'(byp_dir), 64'(mon_byp.dir));
        end
      end
      prev_stall = byp_valid && !byp_ready;
      prev_head  = {byp_dir, byp_data};
    end
  end

  // Random backpressure on the forward side.
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) byp_ready = 1'($urandom_range(0, 1));
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] m);
    int n = 0;
    msg_data  = m;
    msg_valid = 1'b1;
    @(negedge clk);
    while (!msg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!msg_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      msg_valid = 1'b0;
      return;
    end
    expect_msg(m);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_loc.size() != 0 || exp_byp.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_loc.size() + exp_byp.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    check("rst_strobes", {59'd0, act_stb, byp_valid}, 64'd0);
    check("rst_fields", 64'(act_fields), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(msg_ready), 64'd1);
    check("post_rst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_msg();
    logic [3:0] r;
    logic [3:0] c;
    if ($urandom_range(0, 1) == 1) begin
      r = NODE_ROW;
      c = NODE_COL;
    end else begin
      r = 4'($urandom);
      c = 4'($urandom);
      if (r == NODE_ROW && c == NODE_COL) c = c + 4'd1;
    end
    return {r, c, 2'($urandom), 22'($urandom)};
  endfunction

  initial begin
    rst_n     = 1'b1;
    msg_valid = 1'b0;
    msg_data  = '0;
    byp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_strobes", {59'd0, act_stb, byp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(msg_ready), 64'd1);
    check("post_rst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1;

    // Local decode.
    send(32'h2340517D);
    @(negedge clk);
    check("map_strobe_now", 64'(map_valid), 64'd1);
    check("local_no_fwd", 64'(byp_valid), 64'd0);
    @(posedge clk);
    #1;
    send(32'h23800011);
    send(32'h23001234);
    drain();

    // Routing directions with an open forward port.
    byp_ready = 1'b1;
    send(32'h53000000);
    send(32'h21000000);
    send(32'h03000000);
    send(32'h2F000000);
    drain();

    // Backpressure: two accepted, third held off.
    byp_ready = 1'b0;
    send(32'h71000000);
    send(32'h14000000);
    fork
      send(32'h2A000000);
    join_none
    repeat (3) @(negedge clk);
    check("full_ready_low", 64'(msg_ready), 64'd0);
    check("full_byp_valid", 64'(byp_valid), 64'd1);
    check("full_not_idle", 64'(idle), 64'd0);
    @(posedge clk);
    #1 byp_ready = 1'b1;
    wait fork;
    drain();

    // Reserved command.
    send(32'h23C00000);
    drain();

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_msg());
    end
    rand_ready = 1'b0;
    byp_ready  = 1'b1;
    drain();
    @(negedge clk);
    check("idle_after_drain", 64'(idle), 64'd1);
    @(posedge clk);
    #1;

    // Reset with a full FIFO: nothing stale may emerge afterwards.
    byp_ready = 1'b0;
    send(32'h91000000);
    send(32'h05000000);
    @(negedge clk);
    check("prefill_ready_low", 64'(msg_ready), 64'd0);
    @(posedge clk);
    #1;
    pulse_reset();
    byp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_fwd", 64'(byp_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset while a local strobe is high.
    send(32'h23400000);
    pulse_reset();
    repeat (5) @(negedge clk);
    check("no_stale_strobe", 64'(act_stb), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
